// File: rtl/scratchpad_ram_ctl_if.sv
// Bus between the salsa/mix pipeline and the scrypt scratchpad RAM controller.
// It carries the write port, the read port, the read-return channel and the collision counter.
interface scratchpad_ram_ctl_if #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDRBITS   = 10
);
    logic                  ready;
    logic                  rd_en;
    logic [ADDRBITS-1:0]   raddr;
    logic                  wren;
    logic [ADDRBITS-1:0]   waddr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic [15:0]           coll_cnt;

    // Pipeline side: issues requests and consumes read results
    modport master (
        input  ready, q, q_valid, coll_cnt,
        output rd_en, raddr, wren, waddr, data
    );

    // RAM controller side
    modport slave (
        output ready, q, q_valid, coll_cnt,
        input  rd_en, raddr, wren, waddr, data
    );
endinterface

// File: rtl/scratchpad_ram_ctl.sv
// Simple-dual-port scratchpad RAM for the scrypt core.
// It zero-clears the array after reset, has a read latency of 1 or 2 with a valid tag,
// a same-edge write/read bypass and a saturating collision counter.
// READ_LATENCY must be 1 or 2.
module scratchpad_ram_ctl #(
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned ADDRBITS       = 10,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned BYPASS         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    scratchpad_ram_ctl_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDRBITS;
    localparam int unsigned PTR_W = ADDRBITS + 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PTR_W-1:0]    clr_ptr;
    logic [PTR_W-1:0]    clr_ptr_next;
    logic                ready_next;
    logic                clr_we_c;

    logic                acc_rd_c;
    logic                acc_wr_c;
    logic                coll_c;
    logic                mem_we_c;
    logic [ADDRBITS-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    logic [DATA_WIDTH-1:0] store [DEPTH];

    // State, clear pointer and ready registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_ptr   <= '0;
            bus.ready <= 1'b0;
        end else begin
            state     <= state_next;
            clr_ptr   <= clr_ptr_next;
            bus.ready <= ready_next;
        end
    end

    // Next state: walk the clear pointer across the array, then run until reset
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        clr_we_c     = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we_c     = 1'b1;
                clr_ptr_next = clr_ptr + PTR_W'(1);
                if (clr_ptr == PTR_W'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
        endcase
        ready_next = (state_next == ST_RUN);
    end

    // Request acceptance, collision detect and the array write-port mux
    always_comb begin
        acc_rd_c    = bus.rd_en & bus.ready;
        acc_wr_c    = bus.wren & bus.ready;
        coll_c      = acc_rd_c & acc_wr_c & (bus.raddr == bus.waddr);
        mem_we_c    = reset_n & (clr_we_c | acc_wr_c);
        mem_addr_c  = clr_we_c ? clr_ptr[ADDRBITS-1:0] : bus.waddr;
        mem_wdata_c = clr_we_c ? '0 : bus.data;
        rd_word_c   = ((BYPASS != 0) && coll_c) ? bus.data : store[bus.raddr];
    end

    // Storage array; contents are only ever changed through the write port
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            store[mem_addr_c] <= mem_wdata_c;
        end
    end

    // Saturating count of same-edge same-address read/write pairs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.coll_cnt <= '0;
        end else if (coll_c && (bus.coll_cnt != {CNT_W{1'b1}})) begin
            bus.coll_cnt <= bus.coll_cnt + CNT_W'(1);
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s1_data;
            logic                  s1_valid;

            // Two-stage read: the array output is registered first, so later writes cannot disturb it
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    s1_valid    <= 1'b0;
                    s1_data     <= '0;
                    bus.q_valid <= 1'b0;
                    bus.q       <= '0;
                end else begin
                    s1_valid    <= acc_rd_c;
                    if (acc_rd_c) begin
                        s1_data <= rd_word_c;
                    end
                    bus.q_valid <= s1_valid;
                    if (s1_valid) begin
                        bus.q <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read: q holds its last value between accepted reads
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    bus.q_valid <= 1'b0;
                    bus.q       <= '0;
                end else begin
                    bus.q_valid <= acc_rd_c;
                    if (acc_rd_c) begin
                        bus.q <= rd_word_c;
                    end
                end
            end
        end
    endgenerate

endmodule
